// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 transmitter (keyboard emulator).
// Scan codes arrive over a valid/ready handshake. Each one is sent as one
// 11-bit PS/2 frame: start, 8 data bits LSB first, odd parity, stop.
// A break request first sends an 0xF0 prefix frame, then the code frame.
// Every frame is followed by an idle gap with both lines high.
module ps2_keyboard_tx #(
    parameter int unsigned HALF_PERIOD = 1000,
    parameter int unsigned GAP_CYCLES  = 4000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SCAN_CODE,
    input  logic       KEY_BREAK,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       BUSY,
    output logic       TX_DONE,
    output logic       PS2_CLK,
    output logic       PS2_DAT
);

    // One phase counter serves both the clock half periods and the gap.
    localparam int unsigned MAX_COUNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] PHASE_ONE = CW'(1);

    localparam logic [3:0] LAST_BIT    = 4'd10;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] phase_q,  phase_d;
    logic [3:0]    bit_q,    bit_d;
    logic          low_q,    low_d;
    logic [9:0]    shift_q,  shift_d;
    logic [7:0]    code_q,   code_d;
    logic          prefix_q, prefix_d;
    logic          clk_q,    clk_d;
    logic          dat_q,    dat_d;
    logic          done_q,   done_d;

    // Bits b1..b10 of a frame (data LSB first, odd parity, stop), shifted out
    // LSB first after the start bit.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Next-state logic: handshake, bit sequencing and gap timing.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        low_d    = low_q;
        shift_d  = shift_q;
        code_d   = code_q;
        prefix_d = prefix_q;
        clk_d    = clk_q;
        dat_d    = dat_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
                if (TX_VALID) begin
                    code_d   = SCAN_CODE;
                    prefix_d = KEY_BREAK;
                    shift_d  = frame_bits(KEY_BREAK ? BREAK_CODE : SCAN_CODE);
                    state_d  = ST_FRAME;
                    phase_d  = '0;
                    bit_d    = '0;
                    low_d    = 1'b0;
                    dat_d    = 1'b0;
                end
            end

            ST_FRAME: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (!low_q) begin
                        low_d = 1'b1;
                        clk_d = 1'b0;
                    end else begin
                        // Data moves only together with the rising clock.
                        low_d = 1'b0;
                        clk_d = 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_GAP;
                            dat_d   = 1'b1;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            dat_d   = shift_q[0];
                            shift_d = {1'b1, shift_q[9:1]};
                        end
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_GAP: begin
                if (phase_q == GAP_LAST) begin
                    phase_d = '0;
                    if (prefix_q) begin
                        prefix_d = 1'b0;
                        shift_d  = frame_bits(code_q);
                        state_d  = ST_FRAME;
                        bit_d    = '0;
                        low_d    = 1'b0;
                        dat_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                phase_d  = '0;
                prefix_d = 1'b0;
                clk_d    = 1'b1;
                dat_d    = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            low_q    <= 1'b0;
            shift_q  <= '1;
            code_q   <= '0;
            prefix_q <= 1'b0;
            clk_q    <= 1'b1;
            dat_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            low_q    <= low_d;
            shift_q  <= shift_d;
            code_q   <= code_d;
            prefix_q <= prefix_d;
            clk_q    <= clk_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
        end
    end

    assign TX_READY = (state_q == ST_IDLE);
    assign BUSY     = (state_q != ST_IDLE);
    assign TX_DONE  = done_q;
    assign PS2_CLK  = clk_q;
    assign PS2_DAT  = dat_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: directed and random checks of the PS/2 transmitter
// against a frame-level reference model and a bench PS/2 receiver.
module tb_ps2_keyboard_tx;

    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int WAIT_LIMIT = 1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SCAN_CODE = 8'h00;
    logic       KEY_BREAK = 1'b0;
    logic       TX_VALID = 1'b0;
    logic       TX_READY, BUSY, TX_DONE, PS2_CLK, PS2_DAT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ps2_keyboard_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST), .SCAN_CODE(SCAN_CODE), .KEY_BREAK(KEY_BREAK),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY), .TX_DONE(TX_DONE),
        .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: an 11-bit frame packed with b0 in bit 0.
    function automatic int frame_word(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return 1024 + (((ones % 2) == 0) ? 512 : 0) + (int'(b) * 2);
    endfunction

    // Receiver model: validity of a captured frame and its data byte.
    function automatic logic frame_ok(input int w);
        int data9;
        data9 = (w / 2) % 512;
        return ((w % 2) == 0) && (((w / 1024) % 2) == 1) && (($countones(data9[8:0]) % 2) == 1);
    endfunction

    function automatic int frame_data(input int w);
        return (w / 2) % 256;
    endfunction

    function automatic int key_char(input int code);
        case (code)
            8'h1C:   return 65;
            8'h45:   return 48;
            default: return 0;
        endcase
    endfunction

    // Line monitor: samples on falling PS2_CLK, checks line discipline.
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    int          low_len  = 0;
    int          falls    = 0;
    int          nbits    = 0;
    int          done_count = 0;
    logic [10:0] cur = '0;
    int          fall_cyc[$];
    int          frames[$];

    always @(negedge CLK) begin
        if (RST) begin
            prev_clk = 1'b1;
            prev_dat = 1'b1;
            low_len  = 0;
            nbits    = 0;
        end else begin
            if (TX_DONE) done_count++;
            if (prev_clk && !PS2_CLK) begin
                falls++;
                fall_cyc.push_back(cyc);
                cur[nbits[3:0]] = PS2_DAT;
                nbits++;
                if (nbits == 11) begin
                    frames.push_back(int'(cur));
                    nbits = 0;
                end
            end
            if (!prev_clk && !PS2_CLK) check_bit("dat_stable_while_low", PS2_DAT, prev_dat);
            if (!PS2_CLK) low_len++;
            if (!prev_clk && PS2_CLK) begin
                check_int("clk_low_len", low_len, HP);
                low_len = 0;
            end
            prev_clk = PS2_CLK;
            prev_dat = PS2_DAT;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        frames.delete();
        fall_cyc.delete();
        falls = 0;
    endtask

    // Send one request and check the whole sequence against the model.
    task automatic run_tx(input logic [7:0] code, input logic brk, input string tag);
        int acc, budget, busy_low, d0, n_exp, lat_exp;
        int exp_frames[$];
        budget = 0;
        while (!TX_READY && budget < WAIT_LIMIT) begin tick(); budget++; end
        check_bit({tag, "_ready"}, TX_READY, 1'b1);
        clear_mon();
        if (brk) exp_frames.push_back(frame_word(8'hF0));
        exp_frames.push_back(frame_word(code));
        n_exp   = exp_frames.size();
        lat_exp = n_exp * (22 * HP + GAP) + 1;
        d0 = done_count;
        SCAN_CODE = code;
        KEY_BREAK = brk;
        TX_VALID  = 1'b1;
        acc = cyc;
        tick();
        TX_VALID  = 1'b0;
        SCAN_CODE = 8'($urandom);
        KEY_BREAK = 1'($urandom);
        check_bit({tag, "_start_dat"}, PS2_DAT, 1'b0);
        budget = 0;
        busy_low = 0;
        while (!TX_DONE && budget < WAIT_LIMIT) begin
            if (!BUSY) busy_low++;
            tick();
            budget++;
        end
        check_bit({tag, "_done_seen"}, TX_DONE, 1'b1);
        check_int({tag, "_done_latency"}, cyc - acc, lat_exp);
        check_bit({tag, "_ready_at_done"}, TX_READY, 1'b1);
        check_int({tag, "_busy_gaps"}, busy_low, 0);
        check_int({tag, "_done_pulses"}, done_count - d0, 1);
        check_int({tag, "_falls"}, falls, 11 * n_exp);
        if (fall_cyc.size() > 0) check_int({tag, "_first_fall"}, fall_cyc[0] - acc, HP + 1);
        if (brk && fall_cyc.size() > 11) check_int({tag, "_inter_frame"}, fall_cyc[11] - fall_cyc[10], 2 * HP + GAP);
        check_int({tag, "_frame_count"}, frames.size(), n_exp);
        check_int({tag, "_partial_bits"}, nbits, 0);
        for (int i = 0; i < n_exp && i < frames.size(); i++)
            check_int({tag, "_frame"}, frames[i], exp_frames[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int budget, acc, d0, f0;

        // Reset held three cycles.
        RST = 1'b1;
        tick(); tick(); tick();
        check_bit("rst_clk", PS2_CLK, 1'b1);
        check_bit("rst_dat", PS2_DAT, 1'b1);
        check_bit("rst_ready", TX_READY, 1'b1);
        check_bit("rst_busy", BUSY, 1'b0);
        check_bit("rst_done", TX_DONE, 1'b0);
        RST = 1'b0;
        tick();

        // Directed make and break, plus value boundaries.
        run_tx(8'h1C, 1'b0, "make_1c");
        check_int("make_1c_bits", (frames.size() > 0) ? frames[0] : -1, 11'b100_0011_1000);
        run_tx(8'h76, 1'b1, "break_76");
        run_tx(8'h00, 1'b0, "make_00");
        run_tx(8'hFF, 1'b1, "break_ff");

        // Reset in the middle of a frame (around bit 5).
        clear_mon();
        d0 = done_count;
        SCAN_CODE = 8'hA5; KEY_BREAK = 1'b0; TX_VALID = 1'b1;
        tick();
        TX_VALID = 1'b0;
        budget = 0;
        while (falls < 6 && budget < WAIT_LIMIT) begin tick(); budget++; end
        check_int("midrst_reached_bit5", falls, 6);
        RST = 1'b1;
        tick();
        check_bit("midrst_clk", PS2_CLK, 1'b1);
        check_bit("midrst_dat", PS2_DAT, 1'b1);
        check_bit("midrst_ready", TX_READY, 1'b1);
        check_bit("midrst_busy", BUSY, 1'b0);
        check_bit("midrst_done", TX_DONE, 1'b0);
        RST = 1'b0;
        f0 = falls;
        for (int i = 0; i < 22 * HP + GAP + 20; i++) tick();
        check_int("midrst_no_done", done_count - d0, 0);
        check_int("midrst_no_falls", falls - f0, 0);

        // Handshake: TX_VALID held with a changing code while busy.
        clear_mon();
        SCAN_CODE = 8'h3A; KEY_BREAK = 1'b0; TX_VALID = 1'b1;
        tick();
        budget = 0;
        do begin
            SCAN_CODE = 8'($urandom);
            KEY_BREAK = 1'($urandom);
            tick();
            budget++;
        end while (!TX_DONE && budget < WAIT_LIMIT);
        check_bit("hs_done", TX_DONE, 1'b1);
        check_int("hs_frame_count", frames.size(), 1);
        check_int("hs_frame", (frames.size() > 0) ? frames[0] : -1, frame_word(8'h3A));
        // Re-accept in the TX_DONE cycle.
        clear_mon();
        SCAN_CODE = 8'h5B; KEY_BREAK = 1'b0;
        acc = cyc;
        tick();
        TX_VALID = 1'b0;
        check_bit("hs2_start_dat", PS2_DAT, 1'b0);
        check_bit("hs2_busy", BUSY, 1'b1);
        check_bit("hs2_ready", TX_READY, 1'b0);
        budget = 0;
        while (!TX_DONE && budget < WAIT_LIMIT) begin tick(); budget++; end
        check_int("hs2_latency", cyc - acc, 22 * HP + GAP + 1);
        check_int("hs2_frame", (frames.size() > 0) ? frames[0] : -1, frame_word(8'h5B));

        // Loopback through the bench receiver model.
        run_tx(8'h1C, 1'b0, "lb_a");
        check_bit("lb_a_ok", (frames.size() > 0) ? frame_ok(frames[0]) : 1'b0, 1'b1);
        check_int("lb_a_char", (frames.size() > 0) ? key_char(frame_data(frames[0])) : -1, 65);
        run_tx(8'h45, 1'b0, "lb_0");
        check_bit("lb_0_ok", (frames.size() > 0) ? frame_ok(frames[0]) : 1'b0, 1'b1);
        check_int("lb_0_char", (frames.size() > 0) ? key_char(frame_data(frames[0])) : -1, 48);
        run_tx(8'h76, 1'b0, "lb_esc");
        check_bit("lb_esc_ok", (frames.size() > 0) ? frame_ok(frames[0]) : 1'b0, 1'b1);
        check_bit("lb_esc_flag", (frames.size() > 0) ? (frame_data(frames[0]) == 8'h76) : 1'b0, 1'b1);

        // Random codes with random break flag; line checks run throughout.
        for (int n = 0; n < 100; n++)
            run_tx(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
